// File: rtl/baud_gen_param_if.sv
// Control/tick bundle between the baud generator and the UART TX/RX FSMs.
// The master side drives enable, divisor reload and resync; the slave side returns the ticks.
interface baud_gen_param_if #(
  parameter int unsigned DIV_W = 16
);
  logic             en;
  logic             div_load;
  logic [DIV_W-1:0] tx_div_in;
  logic [DIV_W-1:0] rx_div_in;
  logic             rx_resync;
  logic             tx_tick;
  logic             rx_os_tick;
  logic             rx_mid_tick;
  logic             rx_bit_tick;

  modport master (
    output en, div_load, tx_div_in, rx_div_in, rx_resync,
    input  tx_tick, rx_os_tick, rx_mid_tick, rx_bit_tick
  );

  modport slave (
    input  en, div_load, tx_div_in, rx_div_in, rx_resync,
    output tx_tick, rx_os_tick, rx_mid_tick, rx_bit_tick
  );
endinterface

// File: rtl/baud_gen_param.sv
// Runtime-programmable UART baud generator: TX bit tick, RX oversample tick and
// RX mid-bit / end-of-bit strobes, with glitch-free divisor reload, freeze and RX resync.
module baud_gen_param #(
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned TX_DIV_RST = 10417,
  parameter int unsigned RX_DIV_RST = 651
) (
  input  logic               clk,
  input  logic               rst,
  baud_gen_param_if.slave    bus
);

  localparam int unsigned PH_W = $clog2(OVERSAMPLE);
  localparam logic [PH_W-1:0]  PH_MID    = PH_W'(OVERSAMPLE / 2 - 1);
  localparam logic [PH_W-1:0]  PH_END    = PH_W'(OVERSAMPLE - 1);
  localparam logic [DIV_W-1:0] TX_DIV_R0 = DIV_W'(TX_DIV_RST);
  localparam logic [DIV_W-1:0] RX_DIV_R0 = DIV_W'(RX_DIV_RST);
  localparam logic [DIV_W-1:0] DIV_MIN   = DIV_W'(2);
  localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

  // A divisor of 0 or 1 would give a terminal count that never matches or fires every cycle.
  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] v);
    return (v < DIV_MIN) ? DIV_MIN : v;
  endfunction

  logic [DIV_W-1:0] tx_cnt_q,  tx_cnt_d;
  logic [DIV_W-1:0] rx_cnt_q,  rx_cnt_d;
  logic [PH_W-1:0]  rx_phase_q, rx_phase_d;
  logic [DIV_W-1:0] tx_div_q,  tx_div_d;
  logic [DIV_W-1:0] rx_div_q,  rx_div_d;
  logic [DIV_W-1:0] tx_divp_q, tx_divp_d;
  logic [DIV_W-1:0] rx_divp_q, rx_divp_d;
  logic             tx_pend_q, tx_pend_d;
  logic             rx_pend_q, rx_pend_d;
  logic             tx_tick_q, tx_tick_d;
  logic             rx_os_q,   rx_os_d;
  logic             rx_mid_q,  rx_mid_d;
  logic             rx_bit_q,  rx_bit_d;

  logic tx_tc;
  logic rx_tc;

  assign tx_tc = (tx_cnt_q == tx_div_q - DIV_ONE);
  assign rx_tc = (rx_cnt_q == rx_div_q - DIV_ONE);

  always_comb begin
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    rx_phase_d = rx_phase_q;
    tx_div_d   = tx_div_q;
    rx_div_d   = rx_div_q;
    tx_divp_d  = tx_divp_q;
    rx_divp_d  = rx_divp_q;
    tx_pend_d  = tx_pend_q;
    rx_pend_d  = rx_pend_q;
    tx_tick_d  = 1'b0;
    rx_os_d    = 1'b0;
    rx_mid_d   = 1'b0;
    rx_bit_d   = 1'b0;

    if (bus.en) begin
      if (tx_tc) begin
        tx_cnt_d  = '0;
        tx_tick_d = 1'b1;
        if (tx_pend_q) begin
          tx_div_d  = tx_divp_q;
          tx_pend_d = 1'b0;
        end
      end else begin
        tx_cnt_d = tx_cnt_q + DIV_ONE;
      end

      if (bus.rx_resync) begin
        rx_cnt_d   = '0;
        rx_phase_d = '0;
        if (rx_pend_q) begin
          rx_div_d  = rx_divp_q;
          rx_pend_d = 1'b0;
        end
      end else if (rx_tc) begin
        rx_cnt_d   = '0;
        rx_os_d    = 1'b1;
        rx_mid_d   = (rx_phase_q == PH_MID);
        rx_bit_d   = (rx_phase_q == PH_END);
        rx_phase_d = rx_phase_q + PH_W'(1);
        if (rx_pend_q) begin
          rx_div_d  = rx_divp_q;
          rx_pend_d = 1'b0;
        end
      end else begin
        rx_cnt_d = rx_cnt_q + DIV_ONE;
      end

      // Capture comes after application so a load on a terminal count waits for the next one.
      if (bus.div_load) begin
        tx_divp_d = clamp_div(bus.tx_div_in);
        rx_divp_d = clamp_div(bus.rx_div_in);
        tx_pend_d = 1'b1;
        rx_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
      rx_phase_q <= '0;
      tx_div_q   <= TX_DIV_R0;
      rx_div_q   <= RX_DIV_R0;
      tx_divp_q  <= TX_DIV_R0;
      rx_divp_q  <= RX_DIV_R0;
      tx_pend_q  <= 1'b0;
      rx_pend_q  <= 1'b0;
      tx_tick_q  <= 1'b0;
      rx_os_q    <= 1'b0;
      rx_mid_q   <= 1'b0;
      rx_bit_q   <= 1'b0;
    end else begin
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_phase_q <= rx_phase_d;
      tx_div_q   <= tx_div_d;
      rx_div_q   <= rx_div_d;
      tx_divp_q  <= tx_divp_d;
      rx_divp_q  <= rx_divp_d;
      tx_pend_q  <= tx_pend_d;
      rx_pend_q  <= rx_pend_d;
      tx_tick_q  <= tx_tick_d;
      rx_os_q    <= rx_os_d;
      rx_mid_q   <= rx_mid_d;
      rx_bit_q   <= rx_bit_d;
    end
  end

  assign bus.tx_tick     = tx_tick_q;
  assign bus.rx_os_tick  = rx_os_q;
  assign bus.rx_mid_tick = rx_mid_q;
  assign bus.rx_bit_tick = rx_bit_q;

endmodule

// File: tb/tb_baud_gen_param.sv
// Bench for baud_gen_param: countdown-style reference model compared every cycle,
// directed scenarios with literal timing expectations, and a randomized stretch.
module tb_baud_gen_param;
  localparam int unsigned OS  = 4;
  localparam int unsigned TXR = 10417;
  localparam int unsigned RXR = 651;

  logic clk;
  logic rst;
  baud_gen_param_if #(.DIV_W(16)) bif ();

  baud_gen_param #(
    .DIV_W(16), .OVERSAMPLE(OS), .TX_DIV_RST(TXR), .RX_DIV_RST(RXR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [3:0] outs();
    return {bif.rx_bit_tick, bif.rx_mid_tick, bif.rx_os_tick, bif.tx_tick};
  endfunction

  // Reference model: cycles remaining until each tick, plus a running count of
  // oversample ticks since the last resync to locate the mid/end-of-bit strobes.
  int unsigned m_tx_left, m_tx_div, m_tx_pdiv;
  int unsigned m_rx_left, m_rx_div, m_rx_pdiv;
  int unsigned m_os_seen;
  bit          m_tx_pend, m_rx_pend;
  logic [3:0]  m_exp;

  function automatic int unsigned clampv(input int unsigned v);
    return (v < 2) ? 2 : v;
  endfunction

  initial begin
    m_exp = '0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        m_tx_div = TXR; m_tx_pdiv = TXR; m_tx_left = TXR; m_tx_pend = 0;
        m_rx_div = RXR; m_rx_pdiv = RXR; m_rx_left = RXR; m_rx_pend = 0;
        m_os_seen = 0;
        m_exp = '0;
      end else begin
        m_exp = '0;
        if (bif.en) begin
          m_tx_left--;
          if (m_tx_left == 0) begin
            m_exp[0] = 1'b1;
            if (m_tx_pend) begin m_tx_div = m_tx_pdiv; m_tx_pend = 0; end
            m_tx_left = m_tx_div;
          end
          if (bif.rx_resync) begin
            if (m_rx_pend) begin m_rx_div = m_rx_pdiv; m_rx_pend = 0; end
            m_rx_left = m_rx_div;
            m_os_seen = 0;
          end else begin
            m_rx_left--;
            if (m_rx_left == 0) begin
              m_exp[1] = 1'b1;
              m_exp[2] = ((m_os_seen % OS) == OS / 2 - 1);
              m_exp[3] = ((m_os_seen % OS) == OS - 1);
              m_os_seen++;
              if (m_rx_pend) begin m_rx_div = m_rx_pdiv; m_rx_pend = 0; end
              m_rx_left = m_rx_div;
            end
          end
          if (bif.div_load) begin
            m_tx_pdiv = clampv(int'(bif.tx_div_in)); m_tx_pend = 1;
            m_rx_pdiv = clampv(int'(bif.rx_div_in)); m_rx_pend = 1;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      n_cmp++;
      if (outs() !== m_exp) begin
        n_bad++;
        $display("FAIL cycle_outputs t=%0t: got bit/mid/os/tx=%b expected %b", $time, outs(), m_exp);
      end
    end
  end

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Per-window observation: first edge index, count, last period, first four tx edges.
  int unsigned r_first[4], r_cnt[4], r_per[4], r_last[4], r_tx_at[4], r_mb;
  logic [3:0]  r_o1;

  task automatic run(input int unsigned n);
    logic [3:0] o;
    for (int k = 0; k < 4; k++) begin
      r_first[k] = 0; r_cnt[k] = 0; r_per[k] = 0; r_last[k] = 0; r_tx_at[k] = 0;
    end
    r_mb = 0;
    r_o1 = '0;
    for (int unsigned i = 1; i <= n; i++) begin
      @(posedge clk);
      #1;
      bif.div_load  = 1'b0;
      bif.rx_resync = 1'b0;
      o = outs();
      if (i == 1) r_o1 = o;
      if (o[3] && r_cnt[2] > 0) r_mb = i - r_last[2];
      for (int k = 0; k < 4; k++) begin
        if (o[k]) begin
          if (r_cnt[k] == 0) r_first[k] = i;
          else r_per[k] = i - r_last[k];
          if (k == 0 && r_cnt[0] < 4) r_tx_at[r_cnt[0]] = i;
          r_last[k] = i;
          r_cnt[k]++;
        end
      end
    end
  endtask

  task automatic wait_out(input int k, input int unsigned limit, input string name);
    bit hit;
    hit = 0;
    for (int unsigned i = 0; i < limit && !hit; i++) begin
      @(posedge clk);
      #1;
      bif.div_load  = 1'b0;
      bif.rx_resync = 1'b0;
      hit = outs()[k];
    end
    chk(name, hit, 1);
  endtask

  initial begin
    rst = 1'b0;
    bif.en = 1'b0; bif.div_load = 1'b0; bif.rx_resync = 1'b0;
    bif.tx_div_in = '0; bif.rx_div_in = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 0);

    // Release with defaults; a load of 8/2 in the first cycle must not disturb the first ticks.
    rst = 1'b1; bif.en = 1'b1;
    bif.div_load = 1'b1; bif.tx_div_in = 16'd8; bif.rx_div_in = 16'd2;
    run(10420);
    chk("first_tx_edge", r_first[0], TXR);
    chk("first_os_edge", r_first[1], RXR);

    run(64);
    chk("small_tx_period", r_per[0], 8);
    chk("small_os_period", r_per[1], 2);
    chk("small_mid_period", r_per[2], 8);
    chk("small_bit_period", r_per[3], 8);
    chk("mid_to_bit", r_mb, 4);

    wait_out(3, 40, "wait_bit_tick");
    run(2);
    bif.rx_resync = 1'b1;
    run(20);
    chk("resync_quiet", r_o1[3:1], 0);
    chk("resync_first_mid", r_first[2], 5);
    chk("resync_tx_period", r_per[0], 8);

    wait_out(0, 20, "wait_tx_reload");
    run(7);
    bif.div_load = 1'b1; bif.tx_div_in = 16'd5; bif.rx_div_in = 16'd2;
    run(30);
    chk("reload_tick0", r_tx_at[0], 1);
    chk("reload_tick1", r_tx_at[1], 9);
    chk("reload_tick2", r_tx_at[2], 14);
    chk("reload_tick3", r_tx_at[3], 19);

    bif.div_load = 1'b1; bif.tx_div_in = 16'd0; bif.rx_div_in = 16'd1;
    run(20);
    run(40);
    chk("clamp_tx_count", r_cnt[0], 20);
    chk("clamp_os_count", r_cnt[1], 20);
    chk("clamp_tx_period", r_per[0], 2);

    bif.div_load = 1'b1; bif.tx_div_in = 16'd8; bif.rx_div_in = 16'd2;
    run(30);
    wait_out(0, 20, "wait_tx_freeze");
    run(3);
    bif.en = 1'b0;
    run(10);
    chk("freeze_tx_count", r_cnt[0], 0);
    chk("freeze_os_count", r_cnt[1], 0);
    chk("freeze_strobes", r_cnt[2] + r_cnt[3], 0);
    bif.en = 1'b1;
    run(12);
    chk("unfreeze_tx_edge", r_first[0], 5);

    // Randomized stretch; the per-cycle compare carries the checking here.
    for (int unsigned i = 0; i < 3000; i++) begin
      bif.en        = ($urandom_range(9) != 0);
      bif.div_load  = (i == 0) || ($urandom_range(39) == 0);
      bif.tx_div_in = 16'($urandom_range(11));
      bif.rx_div_in = 16'($urandom_range(5));
      bif.rx_resync = ($urandom_range(24) == 0);
      @(posedge clk);
      #1;
    end
    bif.en = 1'b1; bif.div_load = 1'b0; bif.rx_resync = 1'b0;

    // Asynchronous reset while a tick is high.
    wait_out(0, 100, "wait_tx_reset");
    #2;
    rst = 1'b0;
    #1;
    chk("async_reset_outputs", outs(), 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    run(700);
    chk("post_reset_os_edge", r_first[1], RXR);
    chk("post_reset_tx_count", r_cnt[0], 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
